// File: rtl/mycpu_pkg.sv
// Shared CPU-side definitions used by the instruction prefetch queue:
// reset PC default, SRAM-like transfer size encoding, and the queue entry type.
package mycpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [1:0]  INST_SIZE_WORD   = 2'b10;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ipq_entry_t;

    // Sequential fetch advances one 32-bit word; wraps modulo 2^32.
    function automatic logic [31:0] next_word_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ipq_fifo.sv
// Synchronous DEPTH-entry FIFO with flush. Pop is ignored when empty; push is
// accepted when full only if a pop happens in the same cycle. The head word
// reads combinationally and is forced to zero while the FIFO is empty.
module ipq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          push_eff;
    logic          pop_eff;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CW'(DEPTH));
    assign pop_eff  = pop & ~empty;
    assign push_eff = push & (~full | pop_eff);
    assign count    = count_reg;
    assign head     = empty ? '0 : mem_reg[rd_ptr_reg];

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(push_eff) - CW'(pop_eff);
        end
    end

    // Storage: one write-enabled register per entry, no reset needed since
    // the head is masked while empty.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push_eff && !flush && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue between fetch/decode and the SRAM-like
// instruction port. Owns the sequential fetch PC, keeps at most DEPTH fetches
// in flight or buffered, and returns {pc, inst} in order over valid/ready.
// A redirect flushes buffered words, marks every outstanding response
// (including a request still waiting for addr_ok) for discard, and restarts
// fetch at redirect_pc.
// Optional feature macro: IPQ_BYPASS_EN -- when defined, a kept response
// arriving while the buffer is empty is presented combinationally in the same
// cycle and is not buffered if the consumer takes it.
module inst_prefetch_queue
    import mycpu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;

    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [31:0]   inst_addr_reg, inst_addr_next;
    logic          req_reg, req_next;
    logic          stale_reg, stale_next;
    logic [CW-1:0] inflight_reg, inflight_next;
    logic [CW-1:0] discard_reg, discard_next;

    logic          fire;
    logic          hold;
    logic          resp_keep;
    logic          bypass_valid;
    logic          bypass_take;
    logic          data_push;
    logic          data_pop;
    ipq_entry_t    push_entry;
    ipq_entry_t    data_head;
    logic [31:0]   tag_head;
    logic          data_empty, data_full, tag_empty, tag_full;
    logic [CW-1:0] data_count, tag_count;
    logic [OW-1:0] data_count_next;
    logic [OW-1:0] occupancy_next;
    logic          unused_status;

    assign fire      = req_reg & inst_addr_ok;
    assign hold      = req_reg & ~inst_addr_ok;
    assign resp_keep = inst_data_ok & ~redirect_valid & (discard_reg == '0);

`ifdef IPQ_BYPASS_EN
    assign bypass_valid = data_empty & resp_keep;
`else
    assign bypass_valid = 1'b0;
`endif

    assign bypass_take = bypass_valid & out_ready;
    assign data_push   = resp_keep & ~bypass_take;
    assign data_pop    = ~data_empty & out_ready & ~redirect_valid;
    assign push_entry  = '{pc: tag_head, inst: inst_rdata};

    assign out_valid  = ~data_empty | bypass_valid;
    assign out_pc     = bypass_valid ? tag_head   : data_head.pc;
    assign out_inst   = bypass_valid ? inst_rdata : data_head.inst;

    assign inst_req   = req_reg;
    assign inst_addr  = inst_addr_reg;
    assign inst_wr    = 1'b0;
    assign inst_size  = INST_SIZE_WORD;
    assign inst_wdata = 32'd0;

    // Tag FIFO status is not needed: credit keeps it within bounds.
    assign unused_status = ^{data_full, tag_empty, tag_full, tag_count};

    // Next-state for fetch PC, request handshake, credit and discard counters.
    always_comb begin
        inflight_next   = inflight_reg + CW'(fire) - CW'(inst_data_ok);
        data_count_next = redirect_valid ? '0
                        : OW'(data_count) + OW'(data_push) - OW'(data_pop);
        occupancy_next  = OW'(inflight_next) + data_count_next;

        // A request holds until accepted, even across a redirect; otherwise a
        // new one is raised whenever in-flight plus buffered leaves room.
        req_next = hold | (occupancy_next < OW'(DEPTH));

        // A stale request accepted after a redirect must not advance the
        // new stream's PC.
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc;
        end else if (fire && !stale_reg) begin
            fetch_pc_next = next_word_pc(fetch_pc_reg);
        end else begin
            fetch_pc_next = fetch_pc_reg;
        end

        inst_addr_next = hold ? inst_addr_reg : fetch_pc_next;

        if (redirect_valid) begin
            stale_next = hold;
        end else if (fire) begin
            stale_next = 1'b0;
        end else begin
            stale_next = stale_reg;
        end

        // Everything outstanding after this cycle belongs to the old stream,
        // plus the pending request that will be accepted later.
        if (redirect_valid) begin
            discard_next = inflight_next + CW'(hold);
        end else if (inst_data_ok && (discard_reg != '0)) begin
            discard_next = discard_reg - CW'(1);
        end else begin
            discard_next = discard_reg;
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc_reg  <= RESET_PC;
            inst_addr_reg <= RESET_PC;
            req_reg       <= 1'b0;
            stale_reg     <= 1'b0;
            inflight_reg  <= '0;
            discard_reg   <= '0;
        end else begin
            fetch_pc_reg  <= fetch_pc_next;
            inst_addr_reg <= inst_addr_next;
            req_reg       <= req_next;
            stale_reg     <= stale_next;
            inflight_reg  <= inflight_next;
            discard_reg   <= discard_next;
        end
    end

    // Buffered {pc, inst} words waiting for the consumer.
    ipq_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(ipq_entry_t))
    ) u_data_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (redirect_valid),
        .push      (data_push),
        .push_data (push_entry),
        .pop       (data_pop),
        .head      (data_head),
        .count     (data_count),
        .empty     (data_empty),
        .full      (data_full)
    );

    // PC of every accepted request, popped by every response (kept or not).
    ipq_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_tag_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (1'b0),
        .push      (fire),
        .push_data (inst_addr_reg),
        .pop       (inst_data_ok),
        .head      (tag_head),
        .count     (tag_count),
        .empty     (tag_empty),
        .full      (tag_full)
    );

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: a bridge model answers requests in order,
// a stream model predicts which words reach the consumer, and a monitor
// compares every word the consumer accepts against the expected queue.
module tb_inst_prefetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'hBFC0_0000;
`ifdef IPQ_BYPASS_EN
    localparam int          LAT   = 0;
`else
    localparam int          LAT   = 1;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_inst;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = '0;

    inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .inst_req       (inst_req),
        .inst_wr        (inst_wr),
        .inst_size      (inst_size),
        .inst_addr      (inst_addr),
        .inst_wdata     (inst_wdata),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int ep; } breq_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

    breq_t       bq[$];      // accepted requests awaiting a response
    exp_t        exp_q[$];   // words the consumer should still receive
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          fires = 0;
    int          pops = 0;
    logic [31:0] exp_pc = RPC;
    bit          req_seen = 1'b0;
    int          req_ep = 0;
    logic [31:0] req_addr = '0;
    bit          lat_arm = 1'b0;
    int          first_dok_cyc = -1;
    int          first_ov_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every word the consumer takes must be the next expected one.
    always @(negedge clk) begin
        if (resetn) begin
            if (lat_arm && out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
            if (out_valid && out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_out", {out_pc, out_inst}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check({out_pc, out_inst} == {mon_e.pc, mon_e.inst}, "out_word",
                          {out_pc, out_inst}, {mon_e.pc, mon_e.inst});
                    pops++;
                    $display("out pc=%h inst=%h", out_pc, out_inst);
                end
            end
        end
    end

    task automatic do_reset();
        resetn = 1'b0;
        redirect_valid = 1'b0; out_ready = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
        @(posedge clk); #1;
        bq.delete(); exp_q.delete();
        epoch = 0; exp_pc = RPC; req_seen = 1'b0;
        @(posedge clk); #1;
        check(inst_req == 1'b0, "rst_req", inst_req, 0);
        check(inst_addr == RPC, "rst_addr", inst_addr, RPC);
        check(out_valid == 1'b0, "rst_valid", out_valid, 0);
        check({out_pc, out_inst} == 64'd0, "rst_out", {out_pc, out_inst}, 0);
        check({inst_wr, inst_size, inst_wdata} == {1'b0, 2'b10, 32'd0}, "tied",
              {inst_wr, inst_size, inst_wdata}, {1'b0, 2'b10, 32'd0});
        resetn = 1'b1;
        #1;
        check(inst_req == 1'b0, "req_before_edge", inst_req, 0);
    endtask

    // One bridge/consumer cycle; the scoreboard is updated as stimulus issues.
    task automatic do_cycle(input bit rdy, input bit aok, input bit dok_en,
                            input bit redir, input logic [31:0] rpc);
        bit    f, dok;
        breq_t b;
        @(posedge clk); #1;
        if (req_seen) begin
            check(inst_req && inst_addr == req_addr, "req_hold",
                  {inst_req, inst_addr}, {1'b1, req_addr});
            if (!inst_req) req_seen = 1'b0;
        end else if (inst_req) begin
            req_seen = 1'b1; req_ep = epoch; req_addr = inst_addr;
        end
        out_ready = rdy; inst_addr_ok = aok;
        redirect_valid = redir; redirect_pc = rpc;
        dok = dok_en && (bq.size() > 0);
        inst_data_ok = dok;
        inst_rdata = $urandom;
        f = inst_req && aok;
        if (f) check(bq.size() + exp_q.size() < DEPTH, "credit",
                     bq.size() + exp_q.size(), DEPTH - 1);
        if (dok) begin
            b = bq.pop_front();
            if (lat_arm && first_dok_cyc < 0) first_dok_cyc = cyc;
            if (!redir && b.ep == epoch) begin
                exp_q.push_back('{b.addr, inst_rdata});
                check(exp_q.size() <= DEPTH, "fifo_overflow", exp_q.size(), DEPTH);
            end
        end
        if (f) begin
            if (req_ep == epoch && !redir) begin
                check(inst_addr == exp_pc, "fetch_addr", inst_addr, exp_pc);
                exp_pc += 32'd4;
                bq.push_back('{inst_addr, epoch});
            end else begin
                bq.push_back('{inst_addr, -1});
            end
            req_seen = 1'b0;
            fires++;
        end
        if (redir) begin
            exp_q.delete();
            exp_pc = rpc;
            epoch++;
        end
    endtask

    initial begin
        int snap;
        // Sequential stream, everything always ready.
        do_reset();
        lat_arm = 1'b1;
        do_cycle(1, 1, 1, 0, 0);
        check(inst_req && inst_addr == RPC, "first_req", {inst_req, inst_addr}, {1'b1, RPC});
        for (int i = 1; i < 10; i++) do_cycle(1, 1, 1, 0, 0);
        snap = pops;
        for (int i = 0; i < 20; i++) do_cycle(1, 1, 1, 0, 0);
        check(pops - snap == 20, "steady_rate", pops - snap, 20);
        lat_arm = 1'b0;
        check(first_ov_cyc - first_dok_cyc == LAT, "latency", first_ov_cyc - first_dok_cyc, LAT);

        // Consumer stalled: credit limits fires to DEPTH, one pop frees one.
        do_reset();
        snap = fires;
        for (int i = 0; i < 12; i++) do_cycle(0, 1, 1, 0, 0);
        check(fires - snap == DEPTH, "stall_fires", fires - snap, DEPTH);
        check(inst_req == 1'b0, "stall_req_low", inst_req, 0);
        snap = fires;
        do_cycle(1, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) do_cycle(0, 1, 1, 0, 0);
        check(fires - snap == 1, "pop_one_fire", fires - snap, 1);

        // Three in flight, redirect on the third acceptance.
        do_reset();
        do_cycle(1, 1, 0, 0, 0);
        do_cycle(1, 1, 0, 0, 0);
        do_cycle(1, 1, 0, 1, 32'h8000_0100);
        do_cycle(1, 1, 1, 0, 0);
        check(inst_req && inst_addr == 32'h8000_0100, "redir_addr",
              {inst_req, inst_addr}, {1'b1, 32'h8000_0100});
        for (int i = 0; i < 20; i++) do_cycle(1, 1, 1, 0, 0);

        // Redirect while a request waits two cycles for addr_ok.
        do_reset();
        do_cycle(1, 0, 1, 1, 32'h0000_1000);
        do_cycle(1, 0, 1, 0, 0);
        do_cycle(1, 1, 1, 0, 0);
        do_cycle(1, 1, 1, 0, 0);
        check(inst_addr == 32'h0000_1000, "after_stale_addr", inst_addr, 32'h0000_1000);
        for (int i = 0; i < 20; i++) do_cycle(1, 1, 1, 0, 0);

        // Redirect coinciding with response, acceptance and pop.
        do_reset();
        for (int i = 0; i < 8; i++) do_cycle(1, 1, 1, 0, 0);
        do_cycle(1, 1, 1, 1, 32'h0000_2000);
        for (int i = 0; i < 20; i++) do_cycle(1, 1, 1, 0, 0);

        // Random traffic with occasional redirects.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            do_cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 2) != 0,
                     ($urandom % 40) == 0, $urandom & 32'hFFFF_FFFC);
        end
        for (int i = 0; i < 40; i++) do_cycle(1, 0, 1, 0, 0);
        check(bq.size() == 0, "drain_bridge", bq.size(), 0);
        check(exp_q.size() == 0, "drain_words", exp_q.size(), 0);
        check(pops > 200, "throughput", pops, 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
